prog_seq_sram: RTL and testbench

// Parametrised successor to the instruction/data SRAM controller. Buffers a program of

---
 rtl/prog_seq_sram_if.sv | 34 +++
 rtl/prog_seq_sram.sv | 112 +++++++++++
 tb/tb_prog_seq_sram.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_seq_sram_if.sv
// prog_seq_sram_if: load, replay handshake, status and data-read signals of the sequencer
interface prog_seq_sram_if #(
   parameter int INSTR_W = 3,
   parameter int DATA_W  = 13,
   parameter int ADDR_W  = 8
);
   logic               clear;
   logic               load_valid;
   logic [INSTR_W-1:0] load_instr;
   logic               load_ready;
   logic               start;
   logic               loop_en;
   logic               abort;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic               instr_ready;
   logic [DATA_W-1:0]  exec_result;
   logic [ADDR_W-1:0]  rd_addr;
   logic [DATA_W-1:0]  rd_data;
   logic [ADDR_W:0]    prog_len;
   logic [ADDR_W:0]    store_count;
   logic               full;
   logic               busy;
   logic               done;
   logic               ovf;
   modport slave (
      input  clear, load_valid, load_instr, start, loop_en, abort, instr_ready, exec_result, rd_addr,
      output load_ready, instr_valid, instr, rd_data, prog_len, store_count, full, busy, done, ovf
   );
   modport master (
      output clear, load_valid, load_instr, start, loop_en, abort, instr_ready, exec_result, rd_addr,
      input  load_ready, instr_valid, instr, rd_data, prog_len, store_count, full, busy, done, ovf
   );
endinterface

// File: rtl/prog_seq_sram.sv
// prog_seq_sram: buffers a program, replays it over valid/ready and stores STORE_OP results
module prog_seq_sram #(
   parameter int                 INSTR_W  = 3,
   parameter int                 DATA_W   = 13,
   parameter int                 ADDR_W   = 8,
   parameter logic [INSTR_W-1:0] STORE_OP = 3'b010
) (
   input logic            clk,
   input logic            rst,
   prog_seq_sram_if.slave bus
);
   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;
   state_t             state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W:0]    prog_len_q;
   logic [ADDR_W:0]    store_count_q;
   logic               instr_valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic               done_q;
   logic               ovf_q;
   logic [DATA_W-1:0]  rd_data_q;
   logic [INSTR_W-1:0] imem [DEPTH];
   logic [DATA_W-1:0]  dmem [DEPTH];
   logic               load_ready;
   logic               load_we;
   logic               hs;
   logic               store;
   logic               dmem_we;
   logic               last;
   assign load_ready = state_q == IDLE && prog_len_q != DEPTH_C && !bus.start;
   assign load_we    = load_ready && bus.load_valid && !bus.clear;
   assign hs         = state_q == ISSUE && bus.instr_ready;
   assign store      = hs && instr_q == STORE_OP;
   assign dmem_we    = store && store_count_q != DEPTH_C;
   assign last       = {1'b0, pc_q} == prog_len_q - CNT_ONE;
   assign bus.load_ready  = load_ready;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr       = instr_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.prog_len    = prog_len_q;
   assign bus.store_count = store_count_q;
   assign bus.full        = prog_len_q == DEPTH_C;
   assign bus.busy        = state_q == FETCH || state_q == ISSUE;
   assign bus.done        = done_q;
   assign bus.ovf         = ovf_q;
   // sequencer FSM; counters, instr and done are registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         prog_len_q    <= '0;
         store_count_q <= '0;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         done_q        <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load_we) prog_len_q <= prog_len_q + CNT_ONE;
         if (dmem_we) store_count_q <= store_count_q + CNT_ONE;
         if (store && !dmem_we) ovf_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (bus.clear) begin
                  prog_len_q    <= '0;
                  store_count_q <= '0;
                  ovf_q         <= 1'b0;
               end else if (bus.start && prog_len_q != '0) begin
                  pc_q    <= '0;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               if (bus.abort) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  instr_q       <= imem[pc_q];
                  instr_valid_q <= 1'b1;
                  state_q       <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.abort || (hs && last && !bus.loop_en)) begin
                  instr_valid_q <= 1'b0;
                  state_q       <= DONE;
                  done_q        <= 1'b1;
               end else if (hs) begin
                  instr_valid_q <= 1'b0;
                  pc_q          <= last ? '0 : pc_q + PC_ONE;
                  state_q       <= FETCH;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   // SRAM writes; contents survive reset
   always_ff @(posedge clk) begin
      if (load_we && !rst) imem[prog_len_q[ADDR_W-1:0]] <= bus.load_instr;
      if (dmem_we && !rst) dmem[store_count_q[ADDR_W-1:0]] <= bus.exec_result;
   end
   // independent read port, old data on same-address collision
   always_ff @(posedge clk) begin
      if (rst) rd_data_q <= '0;
      else rd_data_q <= dmem[bus.rd_addr];
   end
endmodule

// File: tb/tb_prog_seq_sram.sv
// tb_prog_seq_sram: table-driven, hand-written and randomized checks of prog_seq_sram
module tb_prog_seq_sram;
   localparam int DEPTH = 256;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_vec = 0;
   int n_err = 0;
   prog_seq_sram_if bus ();
   prog_seq_sram dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic        ready;
      logic [12:0] res;
      logic        busy;
      logic        valid;
      logic [2:0]  instr;
      logic        done;
   } vec_t;
   vec_t vecs[12];
   logic [2:0]  prog[$];
   logic [12:0] dm[DEPTH];
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask
   task automatic load(input logic [2:0] w);
      bus.load_valid = 1'b1;
      bus.load_instr = w;
      step();
      bus.load_valid = 1'b0;
   endtask
   initial begin
      int idx, sc, cyc, hs;
      logic [7:0] r;
      bus.clear = 0; bus.load_valid = 0; bus.load_instr = 0; bus.start = 0; bus.loop_en = 0;
      bus.abort = 0; bus.instr_ready = 0; bus.exec_result = 0; bus.rd_addr = 0;
      step();
      step();
      chk("rst busy", bus.busy, 0);
      chk("rst instr_valid", bus.instr_valid, 0);
      chk("rst instr", bus.instr, 0);
      chk("rst done", bus.done, 0);
      chk("rst ovf", bus.ovf, 0);
      chk("rst prog_len", bus.prog_len, 0);
      chk("rst store_count", bus.store_count, 0);
      chk("rst rd_data", bus.rd_data, 0);
      rst = 1'b0;
      // basic replay of 1,2,1,0,2 with stores of 0x0AB and 0x1FFF
      vecs[0]  = '{1, 13'h0,    1, 0, 0, 0};
      vecs[1]  = '{1, 13'h0,    1, 1, 1, 0};
      vecs[2]  = '{1, 13'h0,    1, 0, 0, 0};
      vecs[3]  = '{1, 13'h0AB,  1, 1, 2, 0};
      vecs[4]  = '{1, 13'h0,    1, 0, 0, 0};
      vecs[5]  = '{1, 13'h0,    1, 1, 1, 0};
      vecs[6]  = '{1, 13'h0,    1, 0, 0, 0};
      vecs[7]  = '{1, 13'h0,    1, 1, 0, 0};
      vecs[8]  = '{1, 13'h0,    1, 0, 0, 0};
      vecs[9]  = '{1, 13'h1FFF, 1, 1, 2, 0};
      vecs[10] = '{1, 13'h0,    0, 0, 0, 1};
      vecs[11] = '{1, 13'h0,    0, 0, 0, 0};
      load(1); load(2); load(1); load(0); load(2);
      bus.start = 1;
      step();
      bus.start = 0;
      for (int i = 0; i < 12; i++) begin
         bus.instr_ready = vecs[i].ready;
         bus.exec_result = vecs[i].res;
         chk($sformatf("vec%0d busy", i), bus.busy, vecs[i].busy);
         chk($sformatf("vec%0d instr_valid", i), bus.instr_valid, vecs[i].valid);
         chk($sformatf("vec%0d done", i), bus.done, vecs[i].done);
         if (vecs[i].valid) chk($sformatf("vec%0d instr", i), bus.instr, vecs[i].instr);
         step();
      end
      bus.instr_ready = 0;
      chk("t1 store_count", bus.store_count, 2);
      chk("t1 prog_len", bus.prog_len, 5);
      bus.rd_addr = 0;
      step();
      chk("t2 rd_data[0]", bus.rd_data, 13'h0AB);
      bus.rd_addr = 1;
      step();
      chk("t2 rd_data[1]", bus.rd_data, 13'h1FFF);
      // stall in ISSUE, then abort together with a storing handshake
      bus.start = 1;
      step();
      bus.start = 0;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("stall instr_valid", bus.instr_valid, 1);
         chk("stall instr", bus.instr, 1);
         step();
      end
      bus.instr_ready = 1;
      step();
      bus.instr_ready = 0;
      chk("stall fetch valid", bus.instr_valid, 0);
      step();
      chk("stall next instr", bus.instr, 2);
      bus.abort = 1; bus.instr_ready = 1; bus.exec_result = 13'h155;
      step();
      bus.abort = 0; bus.instr_ready = 0;
      chk("abort done", bus.done, 1);
      chk("abort instr_valid", bus.instr_valid, 0);
      chk("abort store_count", bus.store_count, 3);
      bus.rd_addr = 2;
      step();
      chk("abort store data", bus.rd_data, 13'h155);
      chk("done pulse width", bus.done, 0);
      chk("abort idle busy", bus.busy, 0);
      // clear, then start on an empty program
      bus.clear = 1;
      step();
      bus.clear = 0;
      chk("clear prog_len", bus.prog_len, 0);
      chk("clear store_count", bus.store_count, 0);
      bus.start = 1;
      #1;
      chk("start blocks load_ready", bus.load_ready, 0);
      step();
      chk("empty start busy", bus.busy, 0);
      chk("empty start done", bus.done, 0);
      step();
      bus.start = 0;
      #1;
      chk("empty start idle busy", bus.busy, 0);
      chk("empty load_ready", bus.load_ready, 1);
      // fill the program memory with random opcodes
      for (int i = 0; i < DEPTH; i++) begin
         prog.push_back(3'($urandom_range(0, 7)));
         load(prog[i]);
      end
      bus.load_valid = 1; bus.load_instr = 3'd5;
      #1;
      chk("full", bus.full, 1);
      chk("full load_ready", bus.load_ready, 0);
      chk("full prog_len", bus.prog_len, DEPTH);
      step();
      bus.load_valid = 0;
      chk("full extra load ignored", bus.prog_len, DEPTH);
      // random-ready replay against the program/scoreboard model
      bus.start = 1;
      step();
      bus.start = 0;
      idx = 0; sc = 0; cyc = 0;
      while (!bus.done && cyc < 5000) begin
         bus.instr_ready = 1'($urandom_range(0, 1));
         bus.exec_result = 13'($urandom);
         if (bus.instr_valid && bus.instr_ready) begin
            chk($sformatf("replay instr %0d", idx), bus.instr, prog[idx % DEPTH]);
            if (prog[idx % DEPTH] == 3'b010) begin
               if (sc < DEPTH) dm[sc] = bus.exec_result;
               sc++;
            end
            idx++;
         end
         step();
         cyc++;
      end
      bus.instr_ready = 0;
      chk("replay done", bus.done, 1);
      chk("replay count", idx, DEPTH);
      chk("replay store_count", bus.store_count, sc);
      for (int i = 0; i < 4; i++) begin
         if (sc > 0) begin
            r = 8'($urandom_range(0, sc - 1));
            bus.rd_addr = r;
            step();
            chk($sformatf("replay dmem[%0d]", r), bus.rd_data, dm[r]);
         end
      end
      // looped single STORE_OP program overflowing the data SRAM
      bus.clear = 1;
      step();
      bus.clear = 0;
      load(2);
      bus.loop_en = 1; bus.instr_ready = 1; bus.start = 1;
      step();
      bus.start = 0;
      hs = 0; cyc = 0;
      while (hs < DEPTH && cyc < 2000) begin
         if (bus.instr_valid) hs++;
         step();
         cyc++;
      end
      chk("loop store_count at DEPTH", bus.store_count, DEPTH);
      chk("loop ovf before extra", bus.ovf, 0);
      while (hs < DEPTH + 1 && cyc < 2000) begin
         if (bus.instr_valid) hs++;
         step();
         cyc++;
      end
      chk("loop handshakes", hs, DEPTH + 1);
      chk("loop ovf", bus.ovf, 1);
      chk("loop store_count held", bus.store_count, DEPTH);
      chk("loop still busy", bus.busy, 1);
      bus.abort = 1;
      step();
      bus.abort = 0;
      chk("loop abort done", bus.done, 1);
      step();
      chk("loop idle", bus.busy, 0);
      chk("ovf sticky", bus.ovf, 1);
      // reset while in ISSUE
      bus.loop_en = 0; bus.instr_ready = 0;
      load(1);
      bus.start = 1;
      step();
      bus.start = 0;
      step();
      chk("pre-rst instr_valid", bus.instr_valid, 1);
      rst = 1;
      step();
      chk("mid rst busy", bus.busy, 0);
      chk("mid rst instr_valid", bus.instr_valid, 0);
      chk("mid rst instr", bus.instr, 0);
      chk("mid rst done", bus.done, 0);
      chk("mid rst ovf", bus.ovf, 0);
      chk("mid rst prog_len", bus.prog_len, 0);
      chk("mid rst store_count", bus.store_count, 0);
      chk("mid rst rd_data", bus.rd_data, 0);
      rst = 0;
      #1;
      chk("post rst load_ready", bus.load_ready, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
